// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: holds the PC, fetches 32-bit instruction words from
// instruction memory and presents them to decode.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   imem_req/imem_addr       fetch request and word-aligned fetch address (registered)
//   imem_ack/imem_rdata      memory response strobe and instruction word
//   inst_valid/inst_ready    valid/ready handshake toward decode
//   inst/op/inst_pc/pc_plus4 instruction payload; op is inst[31:26] or FLUSH_OP
//   branch_taken/target      one-cycle redirect pulse and redirect PC
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  FLUSH_OP = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            squash_q;
  logic            imem_req_q;
  logic [XLEN-1:0] imem_addr_q;
  logic            inst_valid_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic [XLEN-1:0] pc_plus4_q;

  logic [XLEN-1:0] pc_inc_d;
  logic [XLEN-1:0] target_d;

  // Sequential PC increment wraps naturally at 2^32; redirect target is word aligned.
  assign pc_inc_d = pc_q + XLEN'(4);
  assign target_d = branch_target & ALIGN_MASK;

  // Fetch FSM: a redirect outranks every other event except reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC & ALIGN_MASK;
      squash_q     <= 1'b0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC & ALIGN_MASK;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      pc_plus4_q   <= '0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (branch_taken) begin
            // Stay here so the request goes out with the redirected PC.
            pc_q <= target_d;
          end else begin
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_q;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            imem_req_q <= 1'b0;
            squash_q   <= 1'b0;
            if (branch_taken) begin
              pc_q    <= target_d;
              state_q <= S_FETCH;
            end else if (squash_q) begin
              // Word belongs to the path abandoned by an earlier redirect.
              state_q <= S_FETCH;
            end else begin
              inst_q       <= imem_rdata;
              inst_pc_q    <= pc_q;
              pc_plus4_q   <= pc_inc_d;
              pc_q         <= pc_inc_d;
              inst_valid_q <= 1'b1;
              state_q      <= S_HOLD;
            end
          end else if (branch_taken) begin
            // Request must stay stable until acked; mark its word for discard.
            pc_q     <= target_d;
            squash_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (branch_taken) begin
            inst_valid_q <= 1'b0;
            pc_q         <= target_d;
            state_q      <= S_FETCH;
          end else if (inst_ready) begin
            inst_valid_q <= 1'b0;
            state_q      <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign pc_plus4   = pc_plus4_q;

  // Invalid slots present an op that decodes to all-zero controls.
  assign op = inst_valid_q ? inst_q[31:26] : FLUSH_OP;

endmodule
